// File: rtl/lc3_mem_pkg.sv
// Shared types for the LC-3 memory responder: FSM encoding, device
// register offsets within the I/O page and the offset decoder.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_HOLD
    } state_e;

    typedef enum logic [2:0] {
        REG_KBSR,
        REG_KBDR,
        REG_DSR,
        REG_DDR,
        REG_NONE
    } dev_reg_e;

    localparam logic [15:0] OFF_KBSR = 16'h0000;
    localparam logic [15:0] OFF_KBDR = 16'h0002;
    localparam logic [15:0] OFF_DSR  = 16'h0004;
    localparam logic [15:0] OFF_DDR  = 16'h0006;

    // Map an offset inside the device page to the register it selects.
    function automatic dev_reg_e decode_dev(input logic [15:0] off);
        case (off)
            OFF_KBSR: decode_dev = REG_KBSR;
            OFF_KBDR: decode_dev = REG_KBDR;
            OFF_DSR:  decode_dev = REG_DSR;
            OFF_DDR:  decode_dev = REG_DDR;
            default:  decode_dev = REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/lc3_mem_responder_if.sv
// Controller-side memory bus: request held high until the responder
// raises ready, then dropped for at least one cycle.
interface lc3_mem_responder_if;
    logic        mio_en;
    logic        rw;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic        r;
    logic [15:0] mem_rdata;

    modport master (output mio_en, rw, mar, mdr, input r, mem_rdata);
    modport slave  (input mio_en, rw, mar, mdr, output r, mem_rdata);
endinterface

// File: rtl/lc3_io_regs.sv
// Keyboard and display device registers (KBSR/KBDR/DSR/DDR).
// Accesses are applied on the CAPTURE edge signalled by cap_i.
module lc3_io_regs
    import lc3_mem_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cap_i,
    input  logic       we_i,
    input  dev_reg_e   sel_i,
    input  logic       wbit14_i,
    input  logic [7:0] wchar_i,
    output logic [15:0] rdata_o,
    input  logic       kb_valid_i,
    input  logic [7:0] kb_data_i,
    output logic       kb_overrun_o,
    output logic       kb_intr_o,
    output logic       dd_valid_o,
    output logic [7:0] dd_data_o,
    input  logic       dd_ready_i
);
    logic       kb_rdy_q, kb_rdy_d, kb_ie_q, kb_ie_d;
    logic [7:0] kbdr_q, kbdr_d;
    logic       dsr_rdy_q, dsr_rdy_d, dsr_b14_q, dsr_b14_d;
    logic       dd_valid_q, dd_valid_d;
    logic [7:0] dd_data_q, dd_data_d;
    logic       ovr_q, ovr_d;
    logic       rd_kbdr;

    assign rd_kbdr = cap_i & ~we_i & (sel_i == REG_KBDR);

    // Register next-state: keyboard load/overrun, software writes, display handshake.
    always_comb begin
        kb_rdy_d   = kb_rdy_q;
        kb_ie_d    = kb_ie_q;
        kbdr_d     = kbdr_q;
        dsr_rdy_d  = dsr_rdy_q;
        dsr_b14_d  = dsr_b14_q;
        dd_valid_d = dd_valid_q;
        dd_data_d  = dd_data_q;
        ovr_d      = 1'b0;
        if (rd_kbdr) kb_rdy_d = 1'b0;
        // A read-clear in the same cycle frees the slot for the new character.
        if (kb_valid_i) begin
            if (!kb_rdy_q || rd_kbdr) begin
                kbdr_d   = kb_data_i;
                kb_rdy_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        // dd_valid implies DSR not ready, so this never collides with a DDR load.
        if (dd_valid_q && dd_ready_i) begin
            dd_valid_d = 1'b0;
            dsr_rdy_d  = 1'b1;
        end
        if (cap_i && we_i) begin
            case (sel_i)
                REG_KBSR: kb_ie_d   = wbit14_i;
                REG_DSR:  dsr_b14_d = wbit14_i;
                REG_DDR: if (dsr_rdy_q) begin
                    dd_data_d  = wchar_i;
                    dd_valid_d = 1'b1;
                    dsr_rdy_d  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Device register state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            kb_rdy_q   <= 1'b0;
            kb_ie_q    <= 1'b0;
            kbdr_q     <= 8'h00;
            dsr_rdy_q  <= 1'b1;
            dsr_b14_q  <= 1'b0;
            dd_valid_q <= 1'b0;
            dd_data_q  <= 8'h00;
            ovr_q      <= 1'b0;
        end else begin
            kb_rdy_q   <= kb_rdy_d;
            kb_ie_q    <= kb_ie_d;
            kbdr_q     <= kbdr_d;
            dsr_rdy_q  <= dsr_rdy_d;
            dsr_b14_q  <= dsr_b14_d;
            dd_valid_q <= dd_valid_d;
            dd_data_q  <= dd_data_d;
            ovr_q      <= ovr_d;
        end
    end

    // Read mux; unmapped device offsets read as zero.
    always_comb begin
        rdata_o = 16'h0000;
        case (sel_i)
            REG_KBSR: rdata_o = {kb_rdy_q, kb_ie_q, 14'h0};
            REG_KBDR: rdata_o = {8'h00, kbdr_q};
            REG_DSR:  rdata_o = {dsr_rdy_q, dsr_b14_q, 14'h0};
            default:  rdata_o = 16'h0000;
        endcase
    end

    assign kb_overrun_o = ovr_q;
    assign kb_intr_o    = kb_rdy_q & kb_ie_q;
    assign dd_valid_o   = dd_valid_q;
    assign dd_data_o    = dd_data_q;
endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: 4-state access FSM, address decode between the
// synchronous RAM port and the device page, and ready/read-data return.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter logic [15:0] IO_BASE = 16'hFE00
) (
    input  logic        i_Clk,
    input  logic        reset,
    lc3_mem_responder_if.slave bus,
    output logic        ram_en,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_overrun,
    output logic        kb_intr,
    output logic        dd_valid,
    output logic [7:0]  dd_data,
    input  logic        dd_ready
);
    state_e      state_q, state_d;
    logic [15:0] mar_q, mar_d, mdr_q, mdr_d, rdata_q, rdata_d;
    logic        rw_q, rw_d;
    logic        is_dev;
    logic [15:0] dev_off, io_rdata;
    dev_reg_e    sel;

    assign is_dev  = (mar_q >= IO_BASE);
    assign dev_off = mar_q - IO_BASE;
    assign sel     = is_dev ? decode_dev(dev_off) : REG_NONE;

    // Next-state, request latch and read-data capture.
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        rw_d    = rw_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: if (bus.mio_en) begin
                state_d = S_ACCESS;
                mar_d   = bus.mar;
                mdr_d   = bus.mdr;
                rw_d    = bus.rw;
            end
            S_ACCESS:  state_d = S_CAPTURE;
            S_CAPTURE: begin
                state_d = S_HOLD;
                if (!rw_q) rdata_d = is_dev ? io_rdata : ram_rdata;
            end
            S_HOLD:    if (!bus.mio_en) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM and latched request state.
    always_ff @(posedge i_Clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mar_q   <= 16'h0000;
            mdr_q   <= 16'h0000;
            rw_q    <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            rw_q    <= rw_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes are masked by reset so an access interrupted in ACCESS never writes RAM.
    assign ram_en        = (state_q == S_ACCESS) & ~is_dev & ~reset;
    assign ram_we        = ram_en & rw_q;
    assign ram_addr      = mar_q;
    assign ram_wdata     = mdr_q;
    assign bus.r         = (state_q == S_HOLD) & bus.mio_en & ~reset;
    assign bus.mem_rdata = rdata_q;

    lc3_io_regs u_io (
        .clk_i        (i_Clk),
        .rst_i        (reset),
        .cap_i        ((state_q == S_CAPTURE) & is_dev),
        .we_i         (rw_q),
        .sel_i        (sel),
        .wbit14_i     (mdr_q[14]),
        .wchar_i      (mdr_q[7:0]),
        .rdata_o      (io_rdata),
        .kb_valid_i   (kb_valid),
        .kb_data_i    (kb_data),
        .kb_overrun_o (kb_overrun),
        .kb_intr_o    (kb_intr),
        .dd_valid_o   (dd_valid),
        .dd_data_o    (dd_data),
        .dd_ready_i   (dd_ready)
    );
endmodule

// File: tb/tb_lc3_mem_responder.sv
// Randomized bench for lc3_mem_responder with a transaction-level model
// of RAM contents and device register state.
module tb_lc3_mem_responder;
    localparam logic [15:0] IO_BASE = 16'hFE00;

    logic        i_Clk = 1'b0;
    logic        reset;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;
    logic        kb_valid, kb_overrun, kb_intr, dd_valid, dd_ready;
    logic [7:0]  kb_data, dd_data;

    lc3_mem_responder_if bus ();

    lc3_mem_responder #(.IO_BASE(IO_BASE)) dut (
        .i_Clk(i_Clk), .reset(reset), .bus(bus),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .kb_valid(kb_valid), .kb_data(kb_data), .kb_overrun(kb_overrun),
        .kb_intr(kb_intr), .dd_valid(dd_valid), .dd_data(dd_data),
        .dd_ready(dd_ready)
    );

    always #5 i_Clk = ~i_Clk;

    // External synchronous RAM; unwritten words hold a fixed address pattern.
    logic [15:0] ext_ram [0:65535];
    logic        written [0:65535];
    int          wr_cnt = 0;
    logic [15:0] wr_addr, wr_data;

    function automatic logic [15:0] seed(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    always @(posedge i_Clk) begin
        if (ram_en) begin
            if (ram_we) begin
                ext_ram[ram_addr] <= ram_wdata;
                written[ram_addr] <= 1'b1;
                wr_cnt  <= wr_cnt + 1;
                wr_addr <= ram_addr;
                wr_data <= ram_wdata;
            end
            ram_rdata <= written[ram_addr] ? ext_ram[ram_addr] : seed(ram_addr);
        end
    end

    // Reference model.
    logic [15:0] m_ram [logic [15:0]];
    bit          m_kb_rdy, m_kb_ie, m_dsr_rdy, m_dsr14, m_dd_valid;
    logic [7:0]  m_kbdr, m_dd_data;

    int vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_kb_rdy = 0; m_kb_ie = 0; m_kbdr = 8'h00;
        m_dsr_rdy = 1; m_dsr14 = 0; m_dd_valid = 0; m_dd_data = 8'h00;
    endtask

    function automatic logic [15:0] m_read(input logic [15:0] a);
        logic [15:0] off;
        if (a < IO_BASE) return m_ram.exists(a) ? m_ram[a] : seed(a);
        off = a - IO_BASE;
        case (off)
            16'd0:   return {m_kb_rdy, m_kb_ie, 14'h0};
            16'd2:   return {8'h00, m_kbdr};
            16'd4:   return {m_dsr_rdy, m_dsr14, 14'h0};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk_side();
        chk("kb_intr", kb_intr, m_kb_rdy & m_kb_ie);
        chk("dd_valid", dd_valid, m_dd_valid);
        chk("dd_data", dd_data, m_dd_data);
    endtask

    // One complete controller access, optionally with a keystroke landing in CAPTURE.
    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input bit kb_inj, input logic [7:0] kb_ch, output logic [15:0] rd);
        logic [15:0] exp_rd, off;
        int n, wc0, hold;
        bit dev;
        logic en1;
        dev = (a >= IO_BASE);
        off = a - IO_BASE;
        exp_rd = m_read(a);
        wc0 = wr_cnt;
        @(posedge i_Clk); #1;
        bus.mio_en = 1; bus.rw = w; bus.mar = a; bus.mdr = d;
        n = 0; en1 = 0;
        while (!bus.r && n < 10) begin
            @(posedge i_Clk); #1; n++;
            if (n == 1) en1 = ram_en;
            if (kb_inj && n == 2) begin kb_valid = 1; kb_data = kb_ch; end
            if (kb_inj && n == 3) kb_valid = 0;
        end
        kb_valid = 0;
        chk("r_latency", n, 3);
        chk("ram_en_cyc1", en1, !dev);
        if (kb_inj) chk("kb_overrun_inj", kb_overrun, 0);
        rd = bus.mem_rdata;
        hold = $urandom_range(0, 3);
        for (int k = 0; k <= hold; k++) begin
            chk("r_hold", bus.r, 1);
            if (!w) chk("mem_rdata", bus.mem_rdata, exp_rd);
            if (k < hold) begin @(posedge i_Clk); #1; end
        end
        chk("ram_wr_cnt", wr_cnt - wc0, (w && !dev) ? 1 : 0);
        if (w && !dev) begin
            chk("ram_wr_addr", wr_addr, a);
            chk("ram_wr_data", wr_data, d);
        end
        bus.mio_en = 0; #1;
        chk("r_drop", bus.r, 0);
        if (w) begin
            if (!dev) m_ram[a] = d;
            else if (off == 16'd0) m_kb_ie = d[14];
            else if (off == 16'd4) m_dsr14 = d[14];
            else if (off == 16'd6 && m_dsr_rdy) begin
                m_dd_data = d[7:0]; m_dd_valid = 1; m_dsr_rdy = 0;
            end
        end else if (dev && off == 16'd2) m_kb_rdy = 0;
        if (kb_inj) begin
            if (!m_kb_rdy) begin m_kbdr = kb_ch; m_kb_rdy = 1; end
        end
        chk_side();
    endtask

    task automatic kb_press(input logic [7:0] c);
        @(posedge i_Clk); #1; kb_valid = 1; kb_data = c;
        @(posedge i_Clk); #1; kb_valid = 0;
        chk("kb_overrun", kb_overrun, m_kb_rdy);
        if (!m_kb_rdy) begin m_kbdr = c; m_kb_rdy = 1; end
        chk_side();
    endtask

    task automatic dd_accept();
        @(posedge i_Clk); #1; dd_ready = 1;
        @(posedge i_Clk); #1; dd_ready = 0;
        if (m_dd_valid) begin m_dd_valid = 0; m_dsr_rdy = 1; end
        chk_side();
    endtask

    task automatic do_reset();
        @(posedge i_Clk); #1; reset = 1; bus.mio_en = 0;
        @(posedge i_Clk); #1;
        @(posedge i_Clk); #1; reset = 0;
        m_reset();
        chk("rst_r", bus.r, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 16'h0000);
        chk("rst_ram_wdata", ram_wdata, 16'h0000);
        chk("rst_mem_rdata", bus.mem_rdata, 16'h0000);
        chk("rst_kb_overrun", kb_overrun, 0);
        chk_side();
    endtask

    task automatic rand_op();
        logic [15:0] a, rd;
        int t;
        bit w, inj;
        t = $urandom_range(0, 9);
        w = 1'($urandom_range(0, 1));
        inj = 0;
        if (t <= 3) a = 16'($urandom_range(0, 32'hFDFF));
        else if (t <= 6) begin
            case ($urandom_range(0, 4))
                0: a = IO_BASE;
                1: a = IO_BASE + 16'd2;
                2: a = IO_BASE + 16'd4;
                3: a = IO_BASE + 16'd6;
                default: a = IO_BASE + 16'($urandom_range(7, 511));
            endcase
            if (a == IO_BASE + 16'd2 && !w) inj = ($urandom_range(0, 3) == 0);
        end else a = 16'h0000;
        if (t <= 6) access(w, a, 16'($urandom), inj, 8'($urandom), rd);
        else if (t == 7) kb_press(8'($urandom));
        else if (t == 8) dd_accept();
        else repeat ($urandom_range(1, 3)) @(posedge i_Clk);
    endtask

    initial begin
        logic [15:0] rd;
        int wc0, rcnt;
        reset = 1; kb_valid = 0; kb_data = 0; dd_ready = 0;
        bus.mio_en = 0; bus.rw = 0; bus.mar = 0; bus.mdr = 0;
        m_reset();
        do_reset();
        chk("rst_dsr", m_read(IO_BASE + 16'd4), 16'h8000);

        // RAM write then read back, then a second write.
        access(1, 16'h3000, 16'h1234, 0, 0, rd);
        access(0, 16'h3000, 16'h0000, 0, 0, rd);
        chk("ram_read_3000", rd, 16'h1234);
        access(1, 16'h3001, 16'hBEEF, 0, 0, rd);

        // Keyboard: load, status, data, read-clear, overrun.
        kb_press(8'h41);
        access(0, IO_BASE, 0, 0, 0, rd);           chk("kbsr_ready", rd, 16'h8000);
        access(0, IO_BASE + 16'd2, 0, 0, 0, rd);   chk("kbdr_41", rd, 16'h0041);
        access(0, IO_BASE, 0, 0, 0, rd);           chk("kbsr_clr", rd, 16'h0000);
        kb_press(8'h42);
        kb_press(8'h43);
        access(0, IO_BASE + 16'd2, 0, 0, 0, rd);   chk("kbdr_kept", rd, 16'h0042);

        // Interrupt enable and keystroke colliding with a KBDR read-clear.
        access(1, IO_BASE, 16'hFFFF, 0, 0, rd);
        kb_press(8'h50);
        chk("kb_intr_on", kb_intr, 1);
        access(0, IO_BASE + 16'd2, 0, 1, 8'h55, rd); chk("kbdr_old", rd, 16'h0050);
        access(0, IO_BASE, 0, 0, 0, rd);           chk("kbsr_still", rd, 16'hC000);
        access(0, IO_BASE + 16'd2, 0, 0, 0, rd);   chk("kbdr_new", rd, 16'h0055);

        // Display: load, busy status, dropped write, handshake.
        access(1, IO_BASE + 16'd6, 16'h0058, 0, 0, rd);
        chk("dd_valid_set", dd_valid, 1);
        chk("dd_data_58", dd_data, 8'h58);
        access(0, IO_BASE + 16'd4, 0, 0, 0, rd);   chk("dsr_busy", rd, 16'h0000);
        access(1, IO_BASE + 16'd6, 16'h0059, 0, 0, rd);
        chk("dd_data_drop", dd_data, 8'h58);
        dd_accept();
        access(0, IO_BASE + 16'd4, 0, 0, 0, rd);   chk("dsr_ready", rd, 16'h8000);

        // Unmapped device offset.
        access(1, IO_BASE + 16'd8, 16'hFFFF, 0, 0, rd);
        access(0, IO_BASE + 16'd8, 0, 0, 0, rd);   chk("unmapped", rd, 16'h0000);

        // Request withdrawn after one cycle: write still lands, r never rises.
        wc0 = wr_cnt; rcnt = 0;
        @(posedge i_Clk); #1;
        bus.mio_en = 1; bus.rw = 1; bus.mar = 16'h3100; bus.mdr = 16'hA5A5;
        @(posedge i_Clk); #1; bus.mio_en = 0;
        repeat (5) begin @(posedge i_Clk); #1; if (bus.r) rcnt++; end
        chk("abort_no_r", rcnt, 0);
        chk("abort_wr", wr_cnt - wc0, 1);
        m_ram[16'h3100] = 16'hA5A5;
        access(0, 16'h3100, 0, 0, 0, rd);          chk("abort_read", rd, 16'hA5A5);

        for (int i = 0; i < 120; i++) rand_op();

        // Reset during ACCESS of a RAM write with a character pending.
        kb_press(8'h77);
        access(1, IO_BASE + 16'd6, 16'h0031, 0, 0, rd);
        wc0 = wr_cnt;
        @(posedge i_Clk); #1;
        bus.mio_en = 1; bus.rw = 1; bus.mar = 16'h4000; bus.mdr = 16'h7777;
        @(posedge i_Clk); #1; reset = 1; bus.mio_en = 0; #1;
        chk("rst_acc_ram_we", ram_we, 0);
        chk("rst_acc_r", bus.r, 0);
        @(posedge i_Clk); #1; reset = 0;
        m_reset();
        chk("rst_acc_wr", wr_cnt - wc0, 0);
        chk_side();
        access(0, IO_BASE + 16'd4, 0, 0, 0, rd);   chk("rst_dsr_rd", rd, 16'h8000);
        access(0, IO_BASE, 0, 0, 0, rd);           chk("rst_kbsr_rd", rd, 16'h0000);
        access(0, 16'h4000, 0, 0, 0, rd);          chk("rst_no_write", rd, seed(16'h4000));

        for (int i = 0; i < 60; i++) rand_op();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lc3_mem_responder.md
LC3_MEM_RESPONDER -- requirements
Module: lc3_mem_responder

Interface
REQ-001 Parameter IO_BASE, default 16'hFE00: base of the device page; addresses IO_BASE..16'hFFFF are device space, all others are RAM.
REQ-002 i_Clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 mio_en  in  1  request from the controller; held high for the whole access.
REQ-005 rw  in  1  access direction: 0 read, 1 write; stable while mio_en=1.
REQ-006 mar  in  16  access address; stable while mio_en=1.
REQ-007 mdr  in  16  write data; stable while mio_en=1.
REQ-008 r  out  1  ready; access complete.
REQ-009 mem_rdata  out  16  read data; valid while r=1.
REQ-010 ram_en  out  1  RAM access strobe.
REQ-011 ram_we  out  1  RAM write enable.
REQ-012 ram_addr  out  16  RAM address.
REQ-013 ram_wdata  out  16  RAM write data.
REQ-014 ram_rdata  in  16  synchronous RAM read data; valid the cycle after ram_en.
REQ-015 kb_valid  in  1  one-cycle keyboard character strobe.
REQ-016 kb_data  in  8  keyboard character.
REQ-017 kb_overrun  out  1  one-cycle pulse when a character is dropped.
REQ-018 kb_intr  out  1  KBSR[15] & KBSR[14].
REQ-019 dd_valid  out  1  display character pending.
REQ-020 dd_data  out  8  display character.
REQ-021 dd_ready  in  1  display accepts the character when dd_valid & dd_ready.

Function
REQ-022 The FSM SHALL have four states:
- IDLE: goes to ACCESS when mio_en=1; latches mar, mdr and rw.
- ACCESS: goes to CAPTURE.
- CAPTURE: goes to HOLD.
- HOLD: goes to IDLE when mio_en=0.
REQ-023 r SHALL equal (state==HOLD) & mio_en; r rises exactly 3 cycles after the first cycle in which IDLE sees mio_en=1.
REQ-024 While mio_en=1, r and mem_rdata SHALL stay stable until mio_en falls, so the controller may sample r in any later cycle.
REQ-025 mio_en still high in the cycle after r SHALL NOT start a new access; a new access needs at least one cycle of mio_en=0.
REQ-026 RAM access: in ACCESS, for a non-device address, drive ram_en=1, ram_we=rw, ram_addr=latched mar and ram_wdata=latched mdr; ram_en=0 in all other states.
REQ-027 In CAPTURE, a read SHALL register mem_rdata from ram_rdata for RAM, or from the device register for device space.
REQ-028 Device addresses:
- IO_BASE+0 = KBSR
- IO_BASE+2 = KBDR
- IO_BASE+4 = DSR
- IO_BASE+6 = DDR
- any other device address reads 16'h0000 and ignores writes.
REQ-029 KBSR: bit15 = key ready, bit14 = interrupt enable, other bits read 0; writes update bit14 only.
REQ-030 KBDR: reads {8'h00, char}; writes ignored.
REQ-031 kb_valid with KBSR[15]=0 SHALL load KBDR and set KBSR[15].
REQ-032 kb_valid with KBSR[15]=1 SHALL drop the character and pulse kb_overrun.
REQ-033 A KBDR read SHALL clear KBSR[15] in CAPTURE.
REQ-034 kb_valid in the same cycle as a KBDR-read clear: the read returns the old character, the new character loads, and KBSR[15] stays 1.
REQ-035 DSR: bit15 = display ready (reset 1), bit14 = writable, other bits read 0.
REQ-036 A DDR write in CAPTURE with DSR[15]=1 SHALL load dd_data=mdr[7:0], set dd_valid=1 and clear DSR[15].
REQ-037 A DDR write with DSR[15]=0 SHALL be dropped, and r SHALL still assert.
REQ-038 dd_valid & dd_ready SHALL clear dd_valid and set DSR[15] on the next edge.
REQ-039 mio_en falling before HOLD: the access completes internally (writes are committed), r never asserts, and HOLD exits to IDLE.

Reset
REQ-040 On reset the block SHALL:
- go to IDLE;
- drive r, ram_en, ram_we, kb_overrun, dd_valid and kb_intr to 0;
- clear mem_rdata, ram_addr, ram_wdata and dd_data to 0;
- set KBSR=0, KBDR=0 and DSR=16'h8000.
REQ-041 Reset mid-access or with a character pending SHALL abandon the access and discard the character; no RAM write is issued after reset.

Structure
REQ-042 Package lc3_mem_pkg SHALL hold the state encoding and the device register offsets.
REQ-043 Device registers SHALL live in sub-module lc3_io_regs; the FSM, address decode and RAM port stay in the top module.

Verification
REQ-044 Read mar=16'h3000 with RAM holding 16'h1234 -> ram_en in cycle +1, r in cycle +3, mem_rdata=16'h1234 held until mio_en=0.
REQ-045 Write mar=16'h3001, mdr=16'hBEEF -> exactly one cycle with ram_en=ram_we=1, addr 16'h3001, data 16'hBEEF; r stays high until mio_en drops.
REQ-046 kb_valid with 8'h41, then read KBSR and KBDR -> 16'h8000, then 16'h0041; KBSR then reads 16'h0000. A second kb_valid before the KBDR read -> kb_overrun pulses.
REQ-047 Write DDR 16'h0058 with dd_ready=0 -> dd_valid=1, dd_data=8'h58, DSR reads 16'h0000. A second DDR write is dropped. Then dd_ready=1 -> DSR reads 16'h8000.
REQ-048 Assert reset during ACCESS of a RAM write -> no ram_we, r=0, DSR=16'h8000; the next access completes normally.
